// File: rtl/npu_pkg.sv
// Shared definitions for the convolution datapath: pixel width, per-frame
// window count and the flattened-window element index.
package npu_pkg;

    localparam int PIX_W = 8;

    // Number of stride-1, valid-padding windows in one frame.
    function automatic int win_count(input int k_h, input int k_w,
                                     input int img_w, input int img_h);
        return (img_h - k_h + 1) * (img_w - k_w + 1);
    endfunction

    // Position of window element (i, j) inside the flattened window bus.
    function automatic int win_idx(input int i, input int j, input int k_w);
        return i * k_w + j;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One image row of pixel storage. Read and write share the same column
// address so the old pixel is read out while the new one is written in.
module conv_line_buffer
    import npu_pkg::*;
#(
    parameter int IMG_W = 8,
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [COL_W-1:0] col,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] dout
);

    logic [PIX_W-1:0] mem [IMG_W];

    // Row storage; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[col] <= din;
        end
    end

    assign dout = mem[col];

endmodule

// File: rtl/conv_window_gen.sv
// Sliding K_H x K_W window generator over a raster pixel stream.
// Line buffers keep the previous K_H-1 rows; the window itself is a bank of
// shift registers that take one new column per accepted pixel.
module conv_window_gen
    import npu_pkg::*;
#(
    parameter int K_H   = 3,
    parameter int K_W   = 3,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pix_valid,
    output logic                     pix_ready,
    input  logic [7:0]               pix_data,
    output logic                     win_valid,
    input  logic                     win_ready,
    output logic [K_H*K_W*8-1:0]     win_data,
    output logic [$clog2(IMG_H)-1:0] win_row,
    output logic [$clog2(IMG_W)-1:0] win_col,
    output logic                     win_last
);

    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);

    logic [CW-1:0]    col_cnt;
    logic [RW-1:0]    row_cnt;
    logic             accept;
    logic             produce;
    logic             col_last;
    logic             row_last;

    logic [PIX_W-1:0] lb_in   [K_H-1];
    logic [PIX_W-1:0] lb_out  [K_H-1];
    logic [PIX_W-1:0] new_col [K_H];
    logic [PIX_W-1:0] win_reg [K_H][K_W];

    assign pix_ready = !win_valid | win_ready;
    assign accept    = pix_valid & pix_ready;
    assign col_last  = (col_cnt == CW'(IMG_W - 1));
    assign row_last  = (row_cnt == RW'(IMG_H - 1));
    assign produce   = (row_cnt >= RW'(K_H - 1)) && (col_cnt >= CW'(K_W - 1));

    // Line buffer chain: lb[0] holds the previous row, lb[k] the row k+1 back.
    for (genvar k = 0; k < K_H - 1; k++) begin : g_lb
        if (k == 0) begin : g_first
            assign lb_in[k] = pix_data;
        end else begin : g_next
            assign lb_in[k] = lb_out[k-1];
        end

        conv_line_buffer #(
            .IMG_W (IMG_W)
        ) u_lb (
            .clk  (clk),
            .we   (accept),
            .col  (col_cnt),
            .din  (lb_in[k]),
            .dout (lb_out[k])
        );
    end

    // Incoming window column, oldest row on top, new pixel at the bottom.
    always_comb begin
        for (int i = 0; i < K_H; i++) begin
            new_col[i] = '0;
        end
        new_col[K_H-1] = pix_data;
        for (int i = 0; i < K_H - 1; i++) begin
            new_col[i] = lb_out[K_H-2-i];
        end
    end

    // Window shift registers: move left one column per accepted pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < K_H; i++) begin
                for (int j = 0; j < K_W; j++) begin
                    win_reg[i][j] <= '0;
                end
            end
        end else if (accept) begin
            for (int i = 0; i < K_H; i++) begin
                for (int j = 0; j < K_W - 1; j++) begin
                    win_reg[i][j] <= win_reg[i][j+1];
                end
                win_reg[i][K_W-1] <= new_col[i];
            end
        end
    end

    // Raster position counters; wrap at end of row and end of frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (accept) begin
            if (col_last) begin
                col_cnt <= '0;
                row_cnt <= row_last ? '0 : row_cnt + 1'b1;
            end else begin
                col_cnt <= col_cnt + 1'b1;
            end
        end
    end

    // Output handshake and window coordinates; a new window overrides a
    // window consumed on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
        end else if (accept && produce) begin
            win_valid <= 1'b1;
            win_last  <= row_last && col_last;
            win_row   <= row_cnt - RW'(K_H - 1);
            win_col   <= col_cnt - CW'(K_W - 1);
        end else if (win_valid && win_ready) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end
    end

    // Flatten the window registers onto the output bus.
    always_comb begin
        win_data = '0;
        for (int i = 0; i < K_H; i++) begin
            for (int j = 0; j < K_W; j++) begin
                win_data[win_idx(i, j, K_W)*PIX_W +: PIX_W] = win_reg[i][j];
            end
        end
    end

endmodule
